// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer and the compute unit it feeds.
package seq_pkg;

  localparam int unsigned INSTR_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } seq_state_e;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpLoad = 4'h1;
  localparam logic [3:0] OpAdd  = 4'h2;
  localparam logic [3:0] OpSub  = 4'h3;
  localparam logic [3:0] OpAnd  = 4'h4;
  localparam logic [3:0] OpOr   = 4'h5;
  localparam logic [3:0] OpNot  = 4'h6;
  localparam logic [3:0] OpXor  = 4'h7;

endpackage

// File: rtl/seq_prog_mem.sv
// Program buffer: synchronous write, combinational read, contents not reset.
module seq_prog_mem
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Byte-stream program loader and one-word-per-cycle replayer for the compute unit.
// Optional feature: define SEQ_LOOP_EN to make replay wrap to word 0 until halted.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  input  logic               load_mode,
  input  logic               start,
  input  logic               halt,
  output logic [INSTR_W-1:0] instruction,
  output logic               en,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W:0]    prog_len,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam logic [ADDR_W:0] FullLen = (ADDR_W + 1)'(DEPTH);

  seq_state_e         state;
  logic               hi_phase;  // next byte is the upper half of a word
  logic [7:0]         hi_byte;
  logic [ADDR_W:0]    idx;       // next word to issue in RUN
  logic               full;
  logic               last;
  logic               we;
  logic [ADDR_W-1:0]  raddr;
  logic [INSTR_W-1:0] rdata;

  always_comb begin
    full  = (prog_len == FullLen);
    last  = (idx == prog_len);
    we    = (state == StLoad) && load_mode && byte_valid && !full && !hi_phase;
    // Outside an active issue slot the read port parks on word 0, ready for a start or wrap.
    raddr = ((state == StRun) && !last) ? idx[ADDR_W-1:0] : '0;
  end

  seq_prog_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(prog_len[ADDR_W-1:0]),
    .wdata({hi_byte, byte_in}),
    .raddr(raddr),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= StIdle;
      instruction <= '0;
      en          <= 1'b0;
      pc          <= '0;
      prog_len    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      hi_phase    <= 1'b1;
      hi_byte     <= '0;
      idx         <= '0;
    end else begin
      case (state)
        StIdle, StDone: begin
          if (load_mode) begin
            state    <= StLoad;
            prog_len <= '0;
            overflow <= 1'b0;
            hi_phase <= 1'b1;
            done     <= 1'b0;
          end else if (start && (prog_len != '0)) begin
            state       <= StRun;
            instruction <= rdata;
            en          <= 1'b1;
            pc          <= '0;
            idx         <= (ADDR_W + 1)'(1);
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        StLoad: begin
          if (!load_mode) begin
            state    <= StIdle;
            hi_phase <= 1'b1;
          end else if (byte_valid) begin
            if (full) begin
              overflow <= 1'b1;
            end else if (hi_phase) begin
              hi_byte  <= byte_in;
              hi_phase <= 1'b0;
            end else begin
              prog_len <= prog_len + 1'b1;
              hi_phase <= 1'b1;
            end
          end
        end
        StRun: begin
          if (halt) begin
            state       <= StIdle;
            en          <= 1'b0;
            instruction <= '0;
            busy        <= 1'b0;
          end else if (last) begin
`ifdef SEQ_LOOP_EN
            instruction <= rdata;
            pc          <= '0;
            idx         <= (ADDR_W + 1)'(1);
`else
            state       <= StDone;
            en          <= 1'b0;
            instruction <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
`endif
          end else begin
            instruction <= rdata;
            pc          <= idx[ADDR_W-1:0];
            idx         <= idx + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Upstream feeder for the compute unit. Assembles 16-bit instructions from a byte stream into a small on-chip program buffer. On command, it replays the buffer one instruction per cycle into the compute unit's `instruction`/`en` inputs. It is the only source of instructions for the compute unit in the chip top.

## Interface
Parameters:
- `DEPTH`, 16, program buffer depth in words; must be a power of two.
- `ADDR_W`, 4, log2(`DEPTH`).

Ports:
- `clk`  input  1  single clock, rising edge.
- `rstn`  input  1  reset; synchronous, active-low.
- `byte_in`  input  8  program byte.
- `byte_valid`  input  1  qualifies `byte_in` for one cycle; only honoured in LOAD.
- `load_mode`  input  1  level; high requests/holds LOAD.
- `start`  input  1  single-cycle pulse; begins replay.
- `halt`  input  1  single-cycle pulse; aborts replay.
- `instruction`  output  16  instruction to compute unit.
- `en`  output  1  instruction valid, to compute unit.
- `pc`  output  ADDR_W  index of the word currently on `instruction`.
- `prog_len`  output  ADDR_W+1  number of words stored, 0..`DEPTH`.
- `busy`  output  1  high in RUN.
- `done`  output  1  high in DONE.
- `overflow`  output  1  sticky; a byte arrived while the buffer was full.

## Operation
- States: IDLE, LOAD, RUN, DONE. All outputs are registered.
- Reset values: state IDLE, `instruction`=0, `en`=0, `pc`=0, `prog_len`=0, `busy`=0, `done`=0, `overflow`=0, byte phase=high. Buffer contents are not reset.
- IDLE or DONE with `load_mode`=1 → LOAD. Entering LOAD clears `prog_len`, `overflow` and the byte phase. `load_mode` has priority over `start` in the same cycle.
- LOAD byte assembly: the first byte is `instruction[15:8]`, the second is `[7:0]`. On the second byte the word is written at address `prog_len` and `prog_len` increments.
- LOAD when full: with `prog_len`=`DEPTH`, further bytes are dropped and `overflow` is set.
- LOAD exit: `load_mode`=0 → IDLE. A pending half-word is discarded silently. `start` and `halt` are ignored in LOAD.
- IDLE or DONE, `start`=1, `prog_len`≠0 → RUN. `start` with `prog_len`=0 is ignored and the state does not change.
- RUN: on each edge, `instruction`←mem[k], `en`←1, `pc`←k, for k = 0..`prog_len`-1.
- RUN end: on the edge after word `prog_len`-1 is issued, `en`←0, `instruction`←0, state DONE. DONE holds until `start` (replay from 0) or `load_mode`.
- `halt` in RUN: the next edge gives `en`=0 and state IDLE. The program is kept and `pc` holds its last value. `halt` outside RUN is ignored.
- `instruction` is 0 whenever `en`=0.
- Reset mid-operation returns to IDLE on the same edge, with all outputs at their reset values.

## Timing
- Start latency: `start` sampled at edge N → `en`=1 with mem[0] after edge N; mem[k] is valid after edge N+k.
- `en` is high for exactly `prog_len` consecutive cycles, with no bubbles.
- `done` rises after edge N+`prog_len`. `busy` is high over the same cycles as `en`.
- LOAD writes land on the edge of the second byte. The updated `prog_len` is visible the next cycle.

## Configuration
- `SEQ_LOOP_EN` defined: in RUN, after word `prog_len`-1, `pc` wraps to 0 with no gap (`en` stays high). RUN continues until `halt`, and DONE is unreachable.
- `SEQ_LOOP_EN` undefined: replay terminates in DONE as described above.

## Structure
- Package `seq_pkg`:
  - state enum (IDLE, LOAD, RUN, DONE);
  - compute-unit opcode constants: NOP=4'h0, LOAD=4'h1, ADD=4'h2, SUB=4'h3, AND=4'h4, OR=4'h5, NOT=4'h6, XOR=4'h7;
  - `INSTR_W`=16.
- One sub-module, `seq_prog_mem`: a `DEPTH`×16 synchronous-write, combinational-read array with `we`, `waddr`, `wdata`, `raddr`, `rdata`.

## Test plan
- Reset, then load bytes 0x11,0x05,0x12,0x03,0x20,0x12 and pulse `start` → three consecutive `en` cycles carrying 0x1105, 0x1203, 0x2012 with `pc` 0,1,2; `done`=1 the following cycle; `prog_len`=3.
- Load 17 words with `DEPTH`=16 → `prog_len`=16, `overflow`=1; replay issues only the first 16 words.
- Send 3 bytes then drop `load_mode` → `prog_len`=1; the stray byte is not stored.
- `halt` on the second cycle of a 4-word run → exactly 2 `en` cycles, then IDLE with `done`=0. A subsequent `start` replays from 0x…/pc 0.
- `start` with `prog_len`=0, and `start` together with `load_mode` → no `en`; LOAD is entered in the second case.
- With `SEQ_LOOP_EN` and a 2-word program → `en` stays high with pc 0,1,0,1,… until `halt`.
